mem_block_copier: RTL

//   Bus initiator for the byte-addressed, little-endian 32-bit data memory (adr/d_in/mrd/mwr port).

---
 rtl/mem_block_copier.sv | 127 ++++++++++++
 1 files changed

// File: rtl/mem_block_copier.sv
// mem_block_copier: bus initiator that copies a block of 32-bit words from
// src_adr to dst_adr over a single adr/d_in/mrd/mwr memory port. Each word
// takes one read cycle followed by one write cycle. A running 32-bit sum of
// the copied words is kept in checksum.
//
// Handshake: start is a one-cycle request that is only sampled in IDLE; any
// start seen in another state is dropped. busy is high from the cycle after an
// accepted start up to and including the done cycle. done is a one-cycle pulse.
//
// Memory port outputs (adr, mem_wdata, mrd, mwr) are flops loaded on the edge
// that enters the state which owns them. They therefore always show the values
// for the current state.
module mem_block_copier #(
  parameter int          LEN_W    = 16,
  parameter int unsigned ADR_STEP = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [31:0]      src_adr,
  input  logic [31:0]      dst_adr,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  output logic             done,
  output logic [31:0]      checksum,
  output logic [31:0]      adr,
  output logic [31:0]      mem_wdata,
  output logic             mrd,
  output logic             mwr,
  input  logic [31:0]      mem_rdata,
  output logic [1:0]       state_dbg
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [31:0]      STEP = 32'(ADR_STEP);
  localparam logic [LEN_W-1:0] ONE  = 1;

  logic [1:0]       state_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] i_q;
  // rd_ptr_q holds the address of the next word to read. wr_ptr_q holds the
  // address of the word currently being written. Both advance by STEP, so no
  // multiplier is needed, and both wrap mod 2^32.
  logic [31:0]      rd_ptr_q;
  logic [31:0]      wr_ptr_q;

  // Handshake flags and debug output come straight from the state register.
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign state_dbg = state_q;

  // Copy FSM. mem_wdata doubles as the word buffer: it is loaded on the READ
  // edge and driven during WRITE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      len_q     <= '0;
      i_q       <= '0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      checksum  <= '0;
      adr       <= '0;
      mem_wdata <= '0;
      mrd       <= 1'b0;
      mwr       <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            len_q    <= len;
            i_q      <= '0;
            checksum <= '0;
            wr_ptr_q <= dst_adr;
            if (len == '0) begin
              state_q <= S_DONE;
            end else begin
              state_q  <= S_READ;
              adr      <= src_adr;
              mrd      <= 1'b1;
              rd_ptr_q <= src_adr + STEP;
            end
          end
        end
        S_READ: begin
          checksum  <= checksum + mem_rdata;
          mem_wdata <= mem_rdata;
          mrd       <= 1'b0;
          mwr       <= 1'b1;
          adr       <= wr_ptr_q;
          state_q   <= S_WRITE;
        end
        S_WRITE: begin
          i_q       <= i_q + ONE;
          wr_ptr_q  <= wr_ptr_q + STEP;
          mwr       <= 1'b0;
          mem_wdata <= '0;
          if ((i_q + ONE) == len_q) begin
            adr     <= '0;
            state_q <= S_DONE;
          end else begin
            // The next read is issued only after this write has landed. This
            // keeps overlapping forward copies well defined.
            adr      <= rd_ptr_q;
            rd_ptr_q <= rd_ptr_q + STEP;
            mrd      <= 1'b1;
            state_q  <= S_READ;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q   <= S_IDLE;
          adr       <= '0;
          mem_wdata <= '0;
          mrd       <= 1'b0;
          mwr       <= 1'b0;
        end
      endcase
    end
  end

endmodule
